// File: rtl/imem_line_filler_if.sv
// Request/response and BRAM-side signals of the instruction line-fill engine.
// The master side is the requester together with the BRAM; the slave side is the filler.
interface imem_line_filler_if #(
  parameter int MEM_ADDR_W = 14
);
  logic                  immu_read;
  logic [31:0]           immu_addr;
  logic                  immu_done;
  logic [255:0]          immu_read_data;
  logic                  immu_err;
  logic                  busy;
  logic                  mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [31:0]           mem_rdata;

  modport master (
    output immu_read, immu_addr, mem_rdata,
    input  immu_done, immu_read_data, immu_err, busy, mem_en, mem_addr
  );

  modport slave (
    input  immu_read, immu_addr, mem_rdata,
    output immu_done, immu_read_data, immu_err, busy, mem_en, mem_addr
  );
endinterface

// File: rtl/imem_line_filler.sv
// Fills one 256-bit I-cache line from 8 BRAM words; done 8+RD_LATENCY edges after accept (1 edge if out of window).
// No backpressure: one request at a time, immu_read is ignored while busy.
module imem_line_filler #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFFE000,
  parameter int          MEM_ADDR_W = 14,
  parameter int          RD_LATENCY = 1
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  imem_line_filler_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ERR, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] wb_q, wb_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            iss_q, iss_d;
  logic [2:0]            cap_q, cap_d;
  logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [255:0]          line_q, line_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  mem_en_q, mem_en_d;

  logic [31:0]           line_addr;
  logic [31:0]           off;
  logic                  in_range;
  logic [MEM_ADDR_W-1:0] req_wb;
  logic                  unused_addr_bits;

  assign line_addr        = {bus.immu_addr[31:5], 5'b0};
  assign off              = line_addr - BASE_ADDR;
  assign in_range         = (off >> (MEM_ADDR_W + 2)) == 32'd0;
  assign req_wb           = off[MEM_ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.immu_addr[4:0], off[1:0]};

  always_comb begin
    state_d    = state_q;
    wb_d       = wb_q;
    mem_addr_d = mem_addr_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    line_d     = line_q;
    done_d     = 1'b0;
    err_d      = err_q;
    busy_d     = busy_q;
    mem_en_d   = 1'b0;
    // One valid bit per issued word, aligned with the BRAM read latency
    vpipe_d    = (vpipe_q << 1) | RD_LATENCY'(mem_en_q);

    case (state_q)
      S_IDLE: begin
        if (bus.immu_read) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          line_d = '0;
          wb_d   = req_wb;
          cap_d  = 3'd0;
          if (in_range) begin
            state_d    = S_FILL;
            mem_en_d   = 1'b1;
            mem_addr_d = req_wb;
            iss_d      = 4'd1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_FILL: begin
        if (iss_q != 4'd8) begin
          mem_en_d   = 1'b1;
          mem_addr_d = wb_q + MEM_ADDR_W'(iss_q);
          iss_d      = iss_q + 4'd1;
        end
        if (vpipe_q[RD_LATENCY-1]) begin
          line_d[{cap_q, 5'b0} +: 32] = bus.mem_rdata;
          cap_d = cap_q + 3'd1;
          if (cap_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_ERR: begin
        line_d  = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wb_q       <= '0;
      mem_addr_q <= '0;
      iss_q      <= 4'd0;
      cap_q      <= 3'd0;
      vpipe_q    <= '0;
      line_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_q       <= wb_d;
      mem_addr_q <= mem_addr_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      vpipe_q    <= vpipe_d;
      line_q     <= line_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_en_q   <= mem_en_d;
    end
  end

  assign bus.immu_done      = done_q;
  assign bus.immu_read_data = line_q;
  assign bus.immu_err       = err_q;
  assign bus.busy           = busy_q;
  assign bus.mem_en         = mem_en_q;
  assign bus.mem_addr       = mem_addr_q;
endmodule

// File: tb/tb_imem_line_filler.sv
// Directed bench for imem_line_filler; BRAM word at address a reads as 0x10000000+a.
// Three instances cover read latencies 1, 2 and 3.
module tb_imem_line_filler;
  logic clk;
  logic rst_n;

  imem_line_filler_if #(.MEM_ADDR_W(14)) b1 ();
  imem_line_filler_if #(.MEM_ADDR_W(14)) b2 ();
  imem_line_filler_if #(.MEM_ADDR_W(14)) b3 ();

  imem_line_filler #(.RD_LATENCY(1)) u1 (.sys_clk(clk), .rst_n(rst_n), .bus(b1.slave));
  imem_line_filler #(.RD_LATENCY(2)) u2 (.sys_clk(clk), .rst_n(rst_n), .bus(b2.slave));
  imem_line_filler #(.RD_LATENCY(3)) u3 (.sys_clk(clk), .rst_n(rst_n), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] r1, r2a, r2b, r3a, r3b, r3c;
  always @(posedge clk) begin
    if (b1.mem_en) r1 <= 32'h1000_0000 + 32'(b1.mem_addr);
    if (b2.mem_en) r2a <= 32'h1000_0000 + 32'(b2.mem_addr);
    r2b <= r2a;
    if (b3.mem_en) r3a <= 32'h1000_0000 + 32'(b3.mem_addr);
    r3b <= r3a;
    r3c <= r3b;
  end
  assign b1.mem_rdata = r1;
  assign b2.mem_rdata = r2b;
  assign b3.mem_rdata = r3c;

  int           n_cmp;
  int           n_fail;
  int           done_idx;
  logic         en_log   [0:31];
  logic [13:0]  addr_log [0:31];
  logic         busy_log [0:31];
  logic [255:0] got_line;
  logic         got_err;

  function automatic logic [255:0] exp_line(input int base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'h1000_0000 + 32'(base + k);
    return l;
  endfunction

  // Issues one request on instance 1 and logs the edges until done or budget expiry.
  task automatic run_req1(input logic [31:0] a, input int budget);
    @(negedge clk);
    b1.immu_read = 1'b1;
    b1.immu_addr = a;
    done_idx = -1;
    got_line = '0;
    got_err  = 1'b0;
    for (int j = 0; j < budget; j++) begin
      @(posedge clk); #1;
      en_log[j]   = b1.mem_en;
      addr_log[j] = b1.mem_addr;
      busy_log[j] = b1.busy;
      if (j == 0) b1.immu_addr = ~a;
      if (b1.immu_done) begin
        done_idx = j;
        got_line = b1.immu_read_data;
        got_err  = b1.immu_err;
        b1.immu_read = 1'b0;
        break;
      end
    end
    b1.immu_read = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (b1.immu_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", b1.immu_done); end
    n_cmp++; if (b1.immu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", b1.immu_err); end
    n_cmp++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b1.busy); end
    n_cmp++; if (b1.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", b1.mem_en); end
    n_cmp++; if (b1.mem_addr !== 14'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", b1.mem_addr); end
    n_cmp++; if (b1.immu_read_data !== 256'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", b1.immu_read_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_basic();
    logic [255:0] e;
    e = exp_line(0);
    run_req1(32'hFFFF_E000, 20);
    n_cmp++; if (done_idx !== 9) begin n_fail++; $display("FAIL basic_done_edge: got %0d want 9", done_idx); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (en_log[k] !== 1'b1 || addr_log[k] !== 14'(k)) begin
        n_fail++; $display("FAIL basic_issue%0d: got en=%b addr=%0d want en=1 addr=%0d", k, en_log[k], addr_log[k], k);
      end
    end
    n_cmp++; if (en_log[8] !== 1'b0) begin n_fail++; $display("FAIL basic_en_drop: got %b want 0", en_log[8]); end
    n_cmp++; if (got_line !== e) begin n_fail++; $display("FAIL basic_line: got %h want %h", got_line, e); end
    n_cmp++; if (got_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", got_err); end
    @(posedge clk); #1;
    n_cmp++; if (b1.immu_done !== 1'b0 || b1.busy !== 1'b0) begin n_fail++; $display("FAIL basic_after: got done=%b busy=%b want 0 0", b1.immu_done, b1.busy); end
    n_cmp++; if (b1.immu_read_data !== e) begin n_fail++; $display("FAIL basic_hold: got %h want %h", b1.immu_read_data, e); end
  endtask

  task automatic test_unaligned();
    logic [255:0] e;
    e = exp_line(8);
    run_req1(32'hFFFF_E02C, 20);
    n_cmp++; if (done_idx !== 9) begin n_fail++; $display("FAIL unal_done_edge: got %0d want 9", done_idx); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (addr_log[k] !== 14'(8 + k)) begin
        n_fail++; $display("FAIL unal_addr%0d: got %0d want %0d", k, addr_log[k], 8 + k);
      end
    end
    n_cmp++; if (got_line !== e) begin n_fail++; $display("FAIL unal_line: got %h want %h", got_line, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    run_req1(32'h0010_0000, 20);
    n_cmp++; if (done_idx !== 1) begin n_fail++; $display("FAIL oor_done_edge: got %0d want 1", done_idx); end
    n_cmp++; if (en_log[0] !== 1'b0 || en_log[1] !== 1'b0) begin n_fail++; $display("FAIL oor_mem_en: got %b%b want 00", en_log[0], en_log[1]); end
    n_cmp++; if (busy_log[0] !== 1'b1) begin n_fail++; $display("FAIL oor_busy: got %b want 1", busy_log[0]); end
    n_cmp++; if (got_err !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", got_err); end
    n_cmp++; if (got_line !== 256'd0) begin n_fail++; $display("FAIL oor_line: got %h want 0", got_line); end
    @(posedge clk); #1;
    n_cmp++; if (b1.immu_err !== 1'b1 || b1.immu_done !== 1'b0 || b1.busy !== 1'b0) begin
      n_fail++; $display("FAIL oor_after: got err=%b done=%b busy=%b want 1 0 0", b1.immu_err, b1.immu_done, b1.busy);
    end
  endtask

  task automatic test_back_to_back();
    int ndone, first, second;
    logic [23:0] en_vec, en_exp;
    ndone = 0; first = -1; second = -1; en_vec = '0;
    en_exp = 24'h07F8FF;
    @(negedge clk);
    b1.immu_read = 1'b1;
    b1.immu_addr = 32'hFFFF_E000;
    for (int j = 0; j < 24; j++) begin
      @(posedge clk); #1;
      en_vec[j] = b1.mem_en;
      if (b1.immu_done) begin
        if (ndone == 0) first = j; else second = j;
        ndone++;
        if (ndone == 2) b1.immu_read = 1'b0;
      end
    end
    b1.immu_read = 1'b0;
    n_cmp++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", ndone); end
    n_cmp++; if (first !== 9 || second !== 20) begin n_fail++; $display("FAIL b2b_edges: got %0d,%0d want 9,20", first, second); end
    n_cmp++; if (en_vec !== en_exp) begin n_fail++; $display("FAIL b2b_mem_en: got %h want %h", en_vec, en_exp); end
  endtask

  task automatic test_abort();
    logic saw_done;
    logic [255:0] e;
    e = exp_line(16);
    saw_done = 1'b0;
    @(negedge clk);
    b1.immu_read = 1'b1;
    b1.immu_addr = 32'hFFFF_E000;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (b1.mem_addr !== 14'd4 || b1.mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got en=%b addr=%0d want 1 4", b1.mem_en, b1.mem_addr); end
    #2;
    rst_n = 1'b0;
    b1.immu_read = 1'b0;
    #1;
    n_cmp++; if (b1.mem_en !== 1'b0 || b1.busy !== 1'b0 || b1.mem_addr !== 14'd0) begin
      n_fail++; $display("FAIL abort_async: got en=%b busy=%b addr=%0d want 0 0 0", b1.mem_en, b1.busy, b1.mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      if (b1.immu_done) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    run_req1(32'hFFFF_E040, 20);
    n_cmp++; if (done_idx !== 9) begin n_fail++; $display("FAIL abort_refill_edge: got %0d want 9", done_idx); end
    n_cmp++; if (addr_log[0] !== 14'd16) begin n_fail++; $display("FAIL abort_refill_addr: got %0d want 16", addr_log[0]); end
    n_cmp++; if (got_line !== e) begin n_fail++; $display("FAIL abort_refill_line: got %h want %h", got_line, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int d2, d3;
    logic [255:0] l2, l3, e;
    e = exp_line(0);
    d2 = -1; d3 = -1; l2 = '0; l3 = '0;
    @(negedge clk);
    b2.immu_read = 1'b1; b2.immu_addr = 32'hFFFF_E000;
    b3.immu_read = 1'b1; b3.immu_addr = 32'hFFFF_E000;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (b2.immu_done && d2 < 0) begin d2 = j; l2 = b2.immu_read_data; b2.immu_read = 1'b0; end
      if (b3.immu_done && d3 < 0) begin d3 = j; l3 = b3.immu_read_data; b3.immu_read = 1'b0; end
    end
    b2.immu_read = 1'b0;
    b3.immu_read = 1'b0;
    n_cmp++; if (d2 !== 10) begin n_fail++; $display("FAIL lat2_done_edge: got %0d want 10", d2); end
    n_cmp++; if (d3 !== 11) begin n_fail++; $display("FAIL lat3_done_edge: got %0d want 11", d3); end
    n_cmp++; if (l2 !== e) begin n_fail++; $display("FAIL lat2_line: got %h want %h", l2, e); end
    n_cmp++; if (l3 !== e) begin n_fail++; $display("FAIL lat3_line: got %h want %h", l3, e); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    b1.immu_read = 1'b0; b1.immu_addr = '0;
    b2.immu_read = 1'b0; b2.immu_addr = '0;
    b3.immu_read = 1'b0; b3.immu_addr = '0;
    test_reset();
    test_fill_basic();
    test_unaligned();
    test_out_of_range();
    test_back_to_back();
    test_abort();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
